// File: rtl/arbiter_wrr_pkg.sv
// Shared types for the weighted round-robin arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package arbiter_wrr_pkg;

  // Arbiter FSM: IDLE has no grant outstanding; GRANT holds one port until it acknowledges.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/arbiter_wrr_priority_encoder.sv
// Priority encoder: index of the highest-priority set bit, plus a valid flag.
// Latency: purely combinational.
// Backpressure: none; output follows the input every cycle.
module arbiter_wrr_priority_encoder #(
  parameter int WIDTH             = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1,
  parameter int IDX_W             = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] in,
  output logic             valid,
  output logic [IDX_W-1:0] index
);

  // Scan in reverse priority order so the last hit is the highest-priority bit.
  always_comb begin
    valid = 1'b0;
    index = '0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (in[i]) begin
          valid = 1'b1;
          index = IDX_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (in[i]) begin
          valid = 1'b1;
          index = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter: each port gets up to weight[i] back-to-back grants per turn.
// Latency: request to grant 1 cycle; acknowledge to next grant 1 cycle, no idle bubble.
// Backpressure: a grant is held until the granted port acknowledges; its request may drop meanwhile.
module arbiter_wrr
  import arbiter_wrr_pkg::*;
#(
  parameter int PORTS        = 4,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS-1:0]              request,
  input  logic [PORTS-1:0]              acknowledge,
  input  logic [PORTS*WEIGHT_WIDTH-1:0] weight,
  output logic [PORTS-1:0]              grant,
  output logic                          grant_valid,
  output logic [$clog2(PORTS)-1:0]      grant_encoded,
  output logic [WEIGHT_WIDTH-1:0]       grant_credit
);

  localparam int CL_PORTS = $clog2(PORTS);

  arb_state_t              state_q, state_d;
  logic [CL_PORTS-1:0]     pointer_q, pointer_d;
  logic [PORTS-1:0]        grant_q, grant_d;
  logic [CL_PORTS-1:0]     enc_q, enc_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic [PORTS-1:0]        masked_req;
  logic                    masked_vld, raw_vld;
  logic [CL_PORTS-1:0]     masked_idx, raw_idx;
  logic                    win_vld;
  logic [CL_PORTS-1:0]     winner;
  logic [PORTS-1:0]        win_onehot;
  logic [WEIGHT_WIDTH-1:0] win_weight, win_credit;
  logic                    ack_cur;

  // Keep only requesters strictly above the pointer so rotation starts at pointer+1.
  always_comb begin
    masked_req = '0;
    for (int i = 0; i < PORTS; i++) begin
      masked_req[i] = request[i] && (i > int'(pointer_q));
    end
  end

  arbiter_wrr_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1'b1)
  ) u_enc_masked (
    .in    (masked_req),
    .valid (masked_vld),
    .index (masked_idx)
  );

  // Wrap-around fallback: lowest requester overall, which also covers re-granting the pointer port.
  arbiter_wrr_priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1'b1)
  ) u_enc_raw (
    .in    (request),
    .valid (raw_vld),
    .index (raw_idx)
  );

  assign win_vld = raw_vld;
  assign winner  = masked_vld ? masked_idx : raw_idx;
  assign ack_cur = acknowledge[pointer_q];

  // Decode the winner into a one-hot grant and pick up its weight; a zero weight still earns one grant.
  always_comb begin
    win_onehot = '0;
    win_weight = '0;
    for (int i = 0; i < PORTS; i++) begin
      if (winner == CL_PORTS'(i)) begin
        win_onehot[i] = 1'b1;
        win_weight    = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
    end
    win_credit = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
  end

  // Next-state logic: start a grant from IDLE, and on acknowledge either burn credit or re-arbitrate.
  always_comb begin
    state_d   = state_q;
    pointer_d = pointer_q;
    grant_d   = grant_q;
    enc_d     = enc_q;
    credit_d  = credit_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d   = GRANT;
          pointer_d = winner;
          grant_d   = win_onehot;
          enc_d     = winner;
          credit_d  = win_credit;
        end
      end
      GRANT: begin
        if (ack_cur) begin
          if ((credit_q > WEIGHT_WIDTH'(1)) && request[pointer_q]) begin
            credit_d = credit_q - WEIGHT_WIDTH'(1);
          end else if (win_vld) begin
            pointer_d = winner;
            grant_d   = win_onehot;
            enc_d     = winner;
            credit_d  = win_credit;
          end else begin
            state_d  = IDLE;
            grant_d  = '0;
            enc_d    = '0;
            credit_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        grant_d  = '0;
        enc_d    = '0;
        credit_d = '0;
      end
    endcase
  end

  // State register; reset parks the pointer on the last port so port 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pointer_q <= CL_PORTS'(PORTS - 1);
      grant_q   <= '0;
      enc_q     <= '0;
      credit_q  <= '0;
    end else begin
      state_q   <= state_d;
      pointer_q <= pointer_d;
      grant_q   <= grant_d;
      enc_q     <= enc_d;
      credit_q  <= credit_d;
    end
  end

  assign grant         = grant_q;
  assign grant_valid   = |grant_q;
  assign grant_encoded = enc_q;
  assign grant_credit  = credit_q;

endmodule

// File: tb/tb_arbiter_wrr.sv
// Directed bench for the weighted round-robin arbiter with hand-computed expectations.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: acknowledge is driven directly per scenario.
module tb_arbiter_wrr;

  logic        clk;
  logic        rst;
  logic [3:0]  request;
  logic [3:0]  acknowledge;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic        grant_valid;
  logic [1:0]  grant_encoded;
  logic [3:0]  grant_credit;

  int n_cmp;
  int n_bad;

  arbiter_wrr #(
    .PORTS        (4),
    .WEIGHT_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .request       (request),
    .acknowledge   (acknowledge),
    .weight        (weight),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_encoded (grant_encoded),
    .grant_credit  (grant_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Checks grant, encoded index, valid and credit together.
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] e, input logic [3:0] c);
    chk({tag, ".grant"}, 32'(grant), 32'(g));
    chk({tag, ".enc"},   32'(grant_encoded), 32'(e));
    chk({tag, ".valid"}, 32'(grant_valid), 32'(|g));
    chk({tag, ".credit"}, 32'(grant_credit), 32'(c));
  endtask

  logic [3:0] exp_g [8];
  logic [1:0] exp_e [8];
  logic [3:0] exp_c [8];

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    rst         = 1'b1;
    request     = '0;
    acknowledge = '0;
    weight      = 16'h1111;
    #2;
    chk_all("reset", 4'b0000, 2'd0, 4'd0);
    tick();
    chk_all("reset_hold", 4'b0000, 2'd0, 4'd0);
    rst = 1'b0;
    tick();
    chk_all("idle_no_req", 4'b0000, 2'd0, 4'd0);

    // Equal weights, everyone requesting, ack every cycle: 0,1,2,3,0 with no gaps.
    request     = 4'b1111;
    acknowledge = 4'b1111;
    exp_g[0] = 4'b0001; exp_e[0] = 2'd0;
    exp_g[1] = 4'b0010; exp_e[1] = 2'd1;
    exp_g[2] = 4'b0100; exp_e[2] = 2'd2;
    exp_g[3] = 4'b1000; exp_e[3] = 2'd3;
    exp_g[4] = 4'b0001; exp_e[4] = 2'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all($sformatf("rr%0d", i), exp_g[i], exp_e[i], 4'd1);
    end

    // Port 0 weight 3, ports 0 and 1 requesting: 0,0,0,1,0,0,0,1.
    request     = '0;
    acknowledge = '0;
    do_reset();
    weight      = 16'h1113;
    request     = 4'b0011;
    acknowledge = 4'b1111;
    exp_g[0] = 4'b0001; exp_e[0] = 2'd0; exp_c[0] = 4'd3;
    exp_g[1] = 4'b0001; exp_e[1] = 2'd0; exp_c[1] = 4'd2;
    exp_g[2] = 4'b0001; exp_e[2] = 2'd0; exp_c[2] = 4'd1;
    exp_g[3] = 4'b0010; exp_e[3] = 2'd1; exp_c[3] = 4'd1;
    exp_g[4] = 4'b0001; exp_e[4] = 2'd0; exp_c[4] = 4'd3;
    exp_g[5] = 4'b0001; exp_e[5] = 2'd0; exp_c[5] = 4'd2;
    exp_g[6] = 4'b0001; exp_e[6] = 2'd0; exp_c[6] = 4'd1;
    exp_g[7] = 4'b0010; exp_e[7] = 2'd1; exp_c[7] = 4'd1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all($sformatf("wrr%0d", i), exp_g[i], exp_e[i], exp_c[i]);
    end

    // Grant held without ack, even after the request drops; released by ack.
    request     = '0;
    acknowledge = '0;
    do_reset();
    weight      = 16'h1111;
    request     = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) request = 4'b0000;
      chk_all($sformatf("hold%0d", i), 4'b0100, 2'd2, 4'd1);
    end
    acknowledge = 4'b0100;
    tick();
    acknowledge = '0;
    chk_all("hold_release", 4'b0000, 2'd0, 4'd0);
    tick();
    chk_all("hold_idle", 4'b0000, 2'd0, 4'd0);

    // Zero weight on port 1 behaves as weight 1 and re-grants on each ack.
    do_reset();
    weight      = 16'h1101;
    request     = 4'b0010;
    acknowledge = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all($sformatf("w0_%0d", i), 4'b0010, 2'd1, 4'd1);
    end

    // Ack on a non-granted port is ignored; a weight change mid-burst waits for the next load.
    request     = '0;
    acknowledge = '0;
    do_reset();
    weight      = 16'h1113;
    request     = 4'b0001;
    tick();
    chk_all("burst_load", 4'b0001, 2'd0, 4'd3);
    acknowledge = 4'b0010;
    tick();
    chk_all("foreign_ack", 4'b0001, 2'd0, 4'd3);
    weight      = 16'h1115;
    acknowledge = 4'b0001;
    tick();
    chk_all("burst_c2", 4'b0001, 2'd0, 4'd2);
    tick();
    chk_all("burst_c1", 4'b0001, 2'd0, 4'd1);
    tick();
    chk_all("burst_reload", 4'b0001, 2'd0, 4'd5);

    // Pointer rotation from port 2: ports 0 and 3 requesting, 3 wins before wrapping to 0.
    request     = '0;
    acknowledge = '0;
    do_reset();
    weight      = 16'h1111;
    request     = 4'b0100;
    tick();
    chk_all("rot_p2", 4'b0100, 2'd2, 4'd1);
    request     = 4'b1001;
    acknowledge = 4'b0100;
    tick();
    chk_all("rot_p3", 4'b1000, 2'd3, 4'd1);
    acknowledge = 4'b1000;
    tick();
    chk_all("rot_wrap", 4'b0001, 2'd0, 4'd1);

    // Asynchronous reset mid-grant clears outputs before the next edge and holds them.
    acknowledge = '0;
    request     = 4'b1111;
    rst         = 1'b1;
    #1;
    chk_all("arst_now", 4'b0000, 2'd0, 4'd0);
    tick();
    chk_all("arst_hold", 4'b0000, 2'd0, 4'd0);
    rst = 1'b0;
    tick();
    chk_all("arst_first", 4'b0001, 2'd0, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
